// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state encoding, RGB565->RGB332 field map and image defaults
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int NPIX      = IMG_W_DEF * IMG_H_DEF;

  // Bits kept from each RGB565 channel: top 3 of R and G, top 2 of B
  localparam int R_MSB = 15;
  localparam int R_LSB = 13;
  localparam int G_MSB = 10;
  localparam int G_LSB = 8;
  localparam int B_MSB = 4;
  localparam int B_LSB = 3;

  // {pclk, vsync, href, data[7:0]}
  localparam int BUS_W = 11;

  function automatic logic [7:0] rgb565_to_332(input logic [15:0] p);
    return {p[R_MSB:R_LSB], p[G_MSB:G_LSB], p[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// rtl/cam_capture_if.sv - frame-buffer write port: one-cycle strobe with address and RGB332 data
interface cam_capture_if #(
  parameter int AW = 17
) ();

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;

  modport master (output mem_addr, output mem_data, output mem_we);
  modport slave  (input  mem_addr, input  mem_data, input  mem_we);

endinterface

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - two-flop synchronizer for the whole camera bus plus edge detection
module cam_sync_edge
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pclk_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       vsync_s,
  output logic       href_s,
  output logic [7:0] data_s,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_fall
);

  logic [BUS_W-1:0] s1_q, s1_d;
  logic [BUS_W-1:0] s2_q, s2_d;
  // Only the control bits need the third stage; data is taken from s2 at pclk_rise
  logic [2:0]       s3_q, s3_d;

  always_comb begin
    s1_d = {pclk_i, vsync_i, href_i, data_i};
    s2_d = s1_q;
    s3_d = s2_q[BUS_W-1 -: 3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign vsync_s    = s2_q[9];
  assign href_s     = s2_q[8];
  assign data_s     = s2_q[7:0];

  assign pclk_rise  =  s2_q[10] & ~s3_q[2];
  assign vsync_rise =  s2_q[9]  & ~s3_q[1];
  assign vsync_fall = ~s2_q[9]  &  s3_q[1];
  assign href_fall  = ~s2_q[8]  &  s3_q[0];

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera capture: RGB565 byte pairs to RGB332 frame-buffer writes, gated per frame
module cam_capture
  import cam_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CAM_pclk,
  input  logic                 CAM_vsync,
  input  logic                 CAM_href,
  input  logic [7:0]           CAM_px_data,
  input  logic                 cap_en,
  cam_capture_if.master        mem,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err_len
);

  localparam int            NPIX_CFG = IMG_W * IMG_H;
  localparam logic [AW:0]   NPIX_V   = NPIX_CFG[AW:0];

  logic       vsync_s, href_s;
  logic [7:0] data_s;
  logic       pclk_rise, vsync_rise, vsync_fall, href_fall;

  cam_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst),
    .pclk_i     (CAM_pclk),
    .vsync_i    (CAM_vsync),
    .href_i     (CAM_href),
    .data_i     (CAM_px_data),
    .vsync_s    (vsync_s),
    .href_s     (href_s),
    .data_s     (data_s),
    .pclk_rise  (pclk_rise),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  cap_state_e  state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] pix_q, pix_d;
  logic        pend_q, pend_d;
  logic        end_req_q, end_req_d;
  // One bit wider than the address so the count can sit at NPIX after the last pixel
  logic [AW:0] cnt_q, cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        frame_done_q, frame_done_d;
  logic        err_len_q, err_len_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    pix_d        = pix_q;
    pend_d       = 1'b0;
    end_req_d    = end_req_q;
    cnt_d        = cnt_q + (AW+1)'(mem_we_q);
    mem_we_d     = 1'b0;
    mem_data_d   = mem_data_q;
    frame_done_d = 1'b0;
    err_len_d    = err_len_q;

    // Write stage: a pixel formed last cycle goes out now unless the frame is full
    if (pend_q) begin
      if (cnt_d < NPIX_V) begin
        mem_we_d   = 1'b1;
        mem_data_d = rgb565_to_332(pix_q);
      end else begin
        err_len_d  = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (vsync_s) state_d = WAIT_VS;
      end

      WAIT_VS: begin
        if (vsync_fall && cap_en) begin
          state_d   = CAPTURE;
          cnt_d     = '0;
          phase_d   = 1'b0;
          err_len_d = 1'b0;
          end_req_d = 1'b0;
        end
      end

      CAPTURE: begin
        if (vsync_fall) begin
          // Blank never arrived: restart the frame and flag it
          cnt_d     = '0;
          phase_d   = 1'b0;
          mem_we_d  = 1'b0;
          err_len_d = 1'b1;
          end_req_d = 1'b0;
        end else if (vsync_rise || end_req_q) begin
          // Let an in-flight pixel reach memory before closing the frame
          if (pend_q) begin
            end_req_d = 1'b1;
          end else begin
            state_d      = WAIT_VS;
            frame_done_d = 1'b1;
            end_req_d    = 1'b0;
            if (cnt_d != NPIX_V) err_len_d = 1'b1;
          end
        end else if (pclk_rise && href_s) begin
          if (!phase_q) begin
            hi_d    = data_s;
            phase_d = 1'b1;
          end else begin
            pix_d   = {hi_q, data_s};
            phase_d = 1'b0;
            pend_d  = 1'b1;
          end
        end else if (href_fall && phase_q) begin
          err_len_d = 1'b1;
          phase_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      pix_q        <= '0;
      pend_q       <= 1'b0;
      end_req_q    <= 1'b0;
      cnt_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      pix_q        <= pix_d;
      pend_q       <= pend_d;
      end_req_q    <= end_req_d;
      cnt_q        <= cnt_d;
      mem_we_q     <= mem_we_d;
      mem_data_q   <= mem_data_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
    end
  end

  assign mem.mem_addr = cnt_q[AW-1:0];
  assign mem.mem_data = mem_data_q;
  assign mem.mem_we   = mem_we_q;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q == CAPTURE);
  assign err_len      = err_len_q;

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - directed frames against a frame-level model of the expected write stream
module tb_cam_capture;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int AW    = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       CAM_pclk = 1'b0;
  logic       CAM_vsync = 1'b0;
  logic       CAM_href = 1'b0;
  logic [7:0] CAM_px_data = 8'h00;
  logic       cap_en = 1'b0;
  logic       frame_done, busy, err_len;

  cam_capture_if #(.AW(AW)) mem_if ();

  cam_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .CAM_pclk    (CAM_pclk),
    .CAM_vsync   (CAM_vsync),
    .CAM_href    (CAM_href),
    .CAM_px_data (CAM_px_data),
    .cap_en      (cap_en),
    .mem         (mem_if),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          fd_count = 0;
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  logic [11:0] exp_q[$];
  logic [7:0]  wr_log[$];
  int          line_len[$];
  logic [11:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // RGB332 straight from channel arithmetic on the 16-bit value
  function automatic logic [7:0] ref_rgb332(input int p);
    int r, g, b;
    r = (p / 8192) % 8;
    g = (p / 256) % 8;
    b = (p / 8) % 4;
    return 8'(r * 32 + g * 4 + b);
  endfunction

  function automatic logic [7:0] gen_byte(input int pattern, input int ln, input int idx);
    logic [15:0] bars [4];
    logic [15:0] px;
    bars = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    case (pattern)
      0: return (idx % 2 == 0) ? 8'hF8 : 8'h00;
      1: begin
        px = bars[(idx / 2) % 4];
        return (idx % 2 == 0) ? px[15:8] : px[7:0];
      end
      default: return 8'((ln * 16 + idx * 29 + 5) % 256);
    endcase
  endfunction

  always @(negedge clk) begin
    if (mem_if.mem_we === 1'b1) begin
      wr_log.push_back(mem_if.mem_data);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=no_write", mem_if.mem_addr, mem_if.mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(mem_if.mem_addr), 32'(mon_e[11:8]));
        check("write_data", 32'(mem_if.mem_data), 32'(mon_e[7:0]));
      end
    end
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    CAM_pclk = 1'b0;
    CAM_px_data = b;
    tick(2);
    CAM_pclk = 1'b1;
    tick(2);
  endtask

  task automatic idle_pclk(input int n);
    repeat (n) begin
      CAM_pclk = 1'b0;
      tick(2);
      CAM_pclk = 1'b1;
      tick(2);
    end
  endtask

  task automatic model_line(input int pattern, input int ln, input int n);
    int p;
    for (int i = 0; i + 1 < n; i += 2) begin
      p = int'(gen_byte(pattern, ln, i)) * 256 + int'(gen_byte(pattern, ln, i + 1));
      if (m_cnt < NPIX) exp_q.push_back({4'(m_cnt), ref_rgb332(p)});
      else m_err = 1'b1;
      m_cnt++;
    end
    if (n % 2 != 0) m_err = 1'b1;
  endtask

  task automatic send_line(input int pattern, input int ln, input int n, input bit capt);
    if (capt) model_line(pattern, ln, n);
    CAM_pclk = 1'b0;
    CAM_href = 1'b1;
    for (int i = 0; i < n; i++) send_byte(gen_byte(pattern, ln, i));
    CAM_pclk = 1'b0;
    CAM_href = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input bit cap, input bit cap_mid, input int pattern);
    int fd0;
    CAM_vsync = 1'b1;
    CAM_href = 1'b0;
    idle_pclk(3);
    cap_en = cap;
    tick(1);
    CAM_vsync = 1'b0;
    if (cap) begin
      m_cnt = 0;
      m_err = 1'b0;
    end
    idle_pclk(2);
    check("busy_at_start", 32'(busy), 32'(cap));
    foreach (line_len[l]) begin
      send_line(pattern, l, line_len[l], cap);
      if (l == 0) begin
        check("busy_mid_frame", 32'(busy), 32'(cap));
        cap_en = cap_mid;
      end
      idle_pclk(2);
    end
    fd0 = fd_count;
    CAM_vsync = 1'b1;
    if (cap) begin
      if (m_cnt != NPIX) m_err = 1'b1;
      for (int t = 0; t < 30 && fd_count == fd0; t++) tick(1);
    end else begin
      tick(20);
    end
    tick(2);
    check("frame_done_pulses", 32'(fd_count - fd0), cap ? 32'd1 : 32'd0);
    check("err_len", 32'(err_len), 32'(m_err));
    check("busy_after_frame", 32'(busy), 32'd0);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while the bus toggles
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      CAM_pclk = ~CAM_pclk;
      CAM_vsync = (i % 3 == 0);
      CAM_href = (i % 2 == 0);
      CAM_px_data = 8'(i * 37);
      cap_en = 1'b1;
      tick(1);
    end
    check("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_if.mem_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    CAM_pclk = 1'b0;
    CAM_href = 1'b0;
    CAM_vsync = 1'b1;
    rst = 1'b1;
    tick(2);

    // Model pinned to hand-computed conversions
    check("model_F800", 32'(ref_rgb332(16'hF800)), 32'h0E0);
    check("model_07E0", 32'(ref_rgb332(16'h07E0)), 32'h01C);
    check("model_001F", 32'(ref_rgb332(16'h001F)), 32'h003);
    check("model_FFFF", 32'(ref_rgb332(16'hFFFF)), 32'h0FF);

    line_len = '{8, 8};
    wr_log.delete();
    send_frame(1'b1, 1'b1, 0);
    check("solid_write_count", 32'(wr_log.size()), 32'd8);
    check("solid_first_data", 32'(wr_log[0]), 32'h0E0);

    wr_log.delete();
    send_frame(1'b1, 1'b1, 1);
    check("bars_write_count", 32'(wr_log.size()), 32'd8);
    check("bars_red", 32'(wr_log[0]), 32'h0E0);
    check("bars_green", 32'(wr_log[1]), 32'h01C);
    check("bars_blue", 32'(wr_log[2]), 32'h003);
    check("bars_white", 32'(wr_log[3]), 32'h0FF);

    // Capture disabled at frame start, enabled mid-frame: nothing written
    wr_log.delete();
    send_frame(1'b0, 1'b1, 2);
    check("gated_write_count", 32'(wr_log.size()), 32'd0);

    // Enable dropped mid-frame: frame still completes
    wr_log.delete();
    send_frame(1'b1, 1'b0, 2);
    check("late_drop_write_count", 32'(wr_log.size()), 32'(NPIX));

    line_len = '{7, 8, 2};
    send_frame(1'b1, 1'b1, 2);

    line_len = '{8, 8, 6};
    wr_log.delete();
    send_frame(1'b1, 1'b1, 2);
    check("overflow_write_count", 32'(wr_log.size()), 32'(NPIX));

    line_len = '{8, 8};
    send_frame(1'b1, 1'b1, 0);

    // Async reset while a write strobe is on the bus
    CAM_vsync = 1'b1;
    idle_pclk(3);
    cap_en = 1'b1;
    tick(1);
    CAM_vsync = 1'b0;
    idle_pclk(2);
    CAM_href = 1'b1;
    send_byte(8'h07);
    send_byte(8'hE0);
    CAM_pclk = 1'b0;
    CAM_px_data = 8'h1F;
    tick(2);
    #1;
    check("we_in_flight", 32'(mem_if.mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_addr", 32'(mem_if.mem_addr), 32'd0);
    wr_log.delete();
    tick(3);
    CAM_href = 1'b0;
    rst = 1'b1;
    m_err = 1'b0;
    tick(2);

    // Vsync still low after reset: an active line must not start a capture
    send_line(2, 0, 8, 1'b0);
    idle_pclk(4);
    check("no_capture_without_blank", 32'(wr_log.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    wr_log.delete();
    send_frame(1'b1, 1'b1, 1);
    check("post_reset_write_count", 32'(wr_log.size()), 32'(NPIX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
Camera capture stage that sits directly upstream of the frame buffer and VGA path in test_cam. It takes the raw camera bus (CAM_pclk, CAM_vsync, CAM_href, 8-bit bytes in RGB565, high byte first), oversamples it on the system clock, and builds one pixel per two bytes. Each pixel is converted to RGB332 and issued as a single-cycle write into the frame-buffer RAM. Frame capture is gated by cap_en (the capture button path), and frame completion and length errors are reported.

Parameters:
IMG_W, 320, active pixels per line (bytes per line = 2*IMG_W)
IMG_H, 240, active lines per frame
AW, 17, frame-buffer address width; must satisfy 2^AW >= IMG_W*IMG_H

Ports:
clk  in  1  system clock, 100 MHz; CAM_pclk period must be >= 4 clk, each phase >= 2 clk
rst  in  1  asynchronous, active-low reset
CAM_pclk  in  1  camera pixel clock, sampled as data
CAM_vsync  in  1  high = vertical blank; falling edge = frame start
CAM_href  in  1  high during active bytes of a line
CAM_px_data  in  8  camera byte; stable around the CAM_pclk rising edge
cap_en  in  1  level; capture is allowed when 1
mem_addr  out  AW  frame-buffer write address
mem_data  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
mem_we  out  1  one-clk write strobe
frame_done  out  1  one-clk pulse at the end of a captured frame
busy  out  1  high while in CAPTURE
err_len  out  1  sticky length error; cleared at the next captured frame start

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, phase=0, pixel counter=0, synchronizer flops=0.
- Input sync: CAM_pclk, CAM_vsync, CAM_href and CAM_px_data pass together through a 2-flop synchronizer, then one more stage for edge detection.
  - pclk_rise = s2 & ~s3; vsync_fall and vsync_rise are derived the same way. href_fall is derived the same way.
  - All bus qualification uses the synchronized copies taken at pclk_rise.
- FSM states:
  - IDLE -> WAIT_VS when synchronized vsync=1 (blank seen; prevents starting mid-frame after reset).
  - WAIT_VS -> CAPTURE on vsync_fall when cap_en=1. On entry: mem_addr=0, phase=0, err_len=0, busy=1. If cap_en=0 the block stays in WAIT_VS.
  - CAPTURE -> WAIT_VS on vsync_rise: frame_done=1 for 1 clk, busy=0. err_len is set if the pixel count != IMG_W*IMG_H.
  - cap_en dropping mid-frame does not abort; the current frame completes.
- Byte assembly (CAPTURE only), on pclk_rise with href=1:
  - phase=0: latch the high byte, phase<=1.
  - phase=1: form the 16-bit pixel, phase<=0, and issue a write on the next clk.
- RGB332 conversion: mem_data = {p[15:13], p[10:8], p[4:3]}.
- Write timing:
  - mem_we is high exactly 1 clk, registered, with mem_addr/mem_data valid in the same cycle.
  - Latency from the second byte's CAM_pclk pin rise to mem_we is 4 clk.
  - mem_addr increments by 1 in the cycle after each write.
- Line end (href_fall): if phase=1 (odd byte count), set err_len, drop the dangling byte, and force phase=0.
- Overflow: once IMG_W*IMG_H pixels are written, further pixels are dropped (no mem_we, address held at IMG_W*IMG_H-1+1 internally) and err_len is set.
- Simultaneous events:
  - vsync_rise in the same cycle as a pending write: the write completes first, then frame_done follows in the next cycle.
  - vsync_fall while in CAPTURE (missing blank): restart at address 0 and set err_len.
- Outside CAPTURE the block never asserts mem_we.

Decomposition:
- Shared package/header (cam_pkg):
  - state encodings IDLE/WAIT_VS/CAPTURE
  - RGB332 field positions
  - localparam NPIX = IMG_W*IMG_H
- Sub-module cam_sync_edge: the synchronizer plus edge detector, instanced once for the {pclk, vsync, href, data} bundle. Outputs are the synchronized bus plus pclk_rise, vsync_rise, vsync_fall and href_fall.

Test Plan:
- Reset: hold rst=0 with bus toggling -> all outputs 0. Release, with vsync=1 then falling and cap_en=1 -> busy=1, first mem_addr=0.
- Single frame, IMG_W=4, IMG_H=2, bytes F8,00 repeated -> 8 writes, mem_data=E0, addresses 0..7, then frame_done=1 for 1 clk, err_len=0.
- Colour bars F800/07E0/001F/FFFF -> mem_data E0, 1C, 03, FF in order, each with a 1-clk mem_we.
- cap_en=0 at vsync_fall -> no mem_we for the whole frame. cap_en set mid-frame -> capture starts only at the next vsync_fall. cap_en cleared mid-frame -> the current frame still yields all NPIX writes.
- One line with 7 bytes (odd) -> err_len=1, next line starts at phase 0. Frame with NPIX+3 pixels -> exactly NPIX writes, err_len=1.
- Async reset asserted mid-line -> mem_we drops immediately, FSM returns to IDLE, and the next capture waits for a full vsync blank.
